// File: rtl/spi_cmd_master.sv
// Two-byte SPI initiator (command byte then data byte) driving the sbasu3_top slave port.
// Build macro SPI_MISO_SYNC_EN inserts a 2-flop miso synchronizer (then CLK_DIV must be >= 3).
module spi_cmd_master #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] cmd,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_cmd,
   output logic [7:0] rx_data,
   output logic       ss,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);
   typedef enum logic [2:0] {IDLE, CMD_BYTE, CMD_GAP, DATA_BYTE, DATA_GAP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   state_t     state, state_nxt;
   logic [7:0] div_cnt, div_nxt;
   logic [2:0] bit_cnt, bit_nxt;
   logic [7:0] tx_sr, tx_nxt;
   logic [7:0] rx_sr, rx_nxt;
   logic [7:0] data_lat, data_lat_nxt;
   logic [7:0] rx_cmd_nxt, rx_data_nxt;
   logic       ss_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;
   logic       miso_cap;
   logic [7:0] rx_shifted;

`ifdef SPI_MISO_SYNC_EN
   logic [1:0] miso_sync;

   always_ff @(posedge sys_clk) begin
      if (rst) miso_sync <= 2'b00;
      else     miso_sync <= {miso_sync[0], miso};
   end

   assign miso_cap = miso_sync[1];
`else
   assign miso_cap = miso;
`endif

   assign rx_shifted = {rx_sr[6:0], miso_cap};

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= 8'd0;
         bit_cnt  <= 3'd0;
         tx_sr    <= 8'd0;
         rx_sr    <= 8'd0;
         data_lat <= 8'd0;
         rx_cmd   <= 8'd0;
         rx_data  <= 8'd0;
         ss       <= 1'b0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         div_cnt  <= div_nxt;
         bit_cnt  <= bit_nxt;
         tx_sr    <= tx_nxt;
         rx_sr    <= rx_nxt;
         data_lat <= data_lat_nxt;
         rx_cmd   <= rx_cmd_nxt;
         rx_data  <= rx_data_nxt;
         ss       <= ss_nxt;
         sclk     <= sclk_nxt;
         mosi     <= mosi_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   // Every output is computed one cycle ahead so the pins come straight from flops.
   always_comb begin
      state_nxt    = state;
      div_nxt      = div_cnt;
      bit_nxt      = bit_cnt;
      tx_nxt       = tx_sr;
      rx_nxt       = rx_sr;
      data_lat_nxt = data_lat;
      rx_cmd_nxt   = rx_cmd;
      rx_data_nxt  = rx_data;
      ss_nxt       = ss;
      sclk_nxt     = sclk;
      mosi_nxt     = mosi;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = CMD_BYTE;
               tx_nxt       = cmd;
               data_lat_nxt = data;
               rx_nxt       = 8'd0;
               div_nxt      = 8'd0;
               bit_nxt      = 3'd0;
               ss_nxt       = 1'b1;
               sclk_nxt     = 1'b0;
               mosi_nxt     = cmd[7];
               busy_nxt     = 1'b1;
            end else begin
               busy_nxt = 1'b0;
            end
         end
         CMD_BYTE, DATA_BYTE: begin
            if (div_cnt != DIV_LAST) begin
               div_nxt = div_cnt + 8'd1;
            end else if (!sclk) begin
               div_nxt  = 8'd0;
               sclk_nxt = 1'b1;
            end else begin
               // End of a high half: sample miso, then either advance the bit or close the byte.
               div_nxt  = 8'd0;
               sclk_nxt = 1'b0;
               rx_nxt   = rx_shifted;
               if (bit_cnt == 3'd7) begin
                  bit_nxt  = 3'd0;
                  ss_nxt   = 1'b0;
                  mosi_nxt = 1'b0;
                  if (state == CMD_BYTE) begin
                     rx_cmd_nxt = rx_shifted;
                     state_nxt  = CMD_GAP;
                  end else begin
                     rx_data_nxt = rx_shifted;
                     state_nxt   = DATA_GAP;
                  end
               end else begin
                  bit_nxt  = bit_cnt + 3'd1;
                  tx_nxt   = {tx_sr[6:0], 1'b0};
                  mosi_nxt = tx_sr[6];
               end
            end
         end
         CMD_GAP: begin
            if (div_cnt == GAP_LAST) begin
               state_nxt = DATA_BYTE;
               div_nxt   = 8'd0;
               bit_nxt   = 3'd0;
               tx_nxt    = data_lat;
               rx_nxt    = 8'd0;
               ss_nxt    = 1'b1;
               mosi_nxt  = data_lat[7];
            end else begin
               div_nxt = div_cnt + 8'd1;
            end
         end
         DATA_GAP: begin
            if (div_cnt == GAP_LAST) begin
               state_nxt = IDLE;
               div_nxt   = 8'd0;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               div_nxt = div_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            div_nxt   = 8'd0;
            bit_nxt   = 3'd0;
            ss_nxt    = 1'b0;
            sclk_nxt  = 1'b0;
            mosi_nxt  = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
   end
endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
SPI initiator that issues one two-byte transaction (command byte, then data byte) to the sbasu3_top SPI slave port from on-chip logic. Drives ss/sclk/mosi and captures miso for both bytes. Slave-side conventions apply: ss active-high, sclk idle low, MSB first, slave shifts on rising sclk. Lets firmware-less logic or a future board controller send RESET/MODE/GPIO WRITE sequences.

Parameters:
CLK_DIV, 4, sys_clk cycles per sclk half-period; legal range 1..255.
GAP_CYCLES, 2, sys_clk cycles with ss low and sclk low after each byte; legal range 1..255.

Ports:
sys_clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request transaction; sampled only in IDLE
cmd  input  8  command byte, latched on accepted start
data  input  8  data byte, latched on accepted start
busy  output  1  high from cycle after accepted start until done
done  output  1  one-cycle pulse at transaction end
rx_cmd  output  8  miso bits captured during command byte
rx_data  output  8  miso bits captured during data byte
ss  output  1  slave select, active-high
sclk  output  1  SPI clock, idle low
mosi  output  1  serial data to slave
miso  input  1  serial data from slave

Behaviour:
- Reset (synchronous, rst high at rising sys_clk): state=IDLE; ss=0, sclk=0, mosi=0, busy=0, done=0, rx_cmd=0, rx_data=0, shift/divider counters=0. rst wins over start in the same cycle. Reset mid-transfer aborts immediately; next cycle all outputs idle; no done pulse.
- States: IDLE -> CMD_BYTE -> CMD_GAP -> DATA_BYTE -> DATA_GAP -> IDLE.
- IDLE: start=1 latches cmd/data; next cycle enters CMD_BYTE with busy=1, ss=1, sclk=0, mosi=cmd[7]. start while busy ignored; no queueing.
- Byte phase: 16 half-periods of CLK_DIV cycles each. Low half (sclk=0): mosi holds current bit. High half (sclk=1): mosi stable. On the cycle sclk goes 1->0: miso shifted into rx shift register LSB (MSB-first assembly), mosi advances to next bit. After 8th high half: sclk=0 and ss=0 in the same cycle; mosi=0; captured byte copied to rx_cmd (or rx_data). ss high exactly 16*CLK_DIV cycles.
- Gap phase: ss=0, sclk=0, mosi=0 for GAP_CYCLES cycles. CMD_GAP then DATA_BYTE (ss=1, mosi=data[7]). DATA_GAP then IDLE.
- done=1 and busy=0 on the first IDLE cycle; done lasts exactly one cycle. Start accepted at cycle N -> done at cycle N+1+32*CLK_DIV+2*GAP_CYCLES.
- rx_cmd/rx_data hold last values until overwritten by next transaction or reset.
- start high on the done cycle is accepted (back-to-back transactions legal).
- Divider counts 0..CLK_DIV-1 per half-period; bit counter 0..7; no wrap beyond 8 bits.

Optional Feature:
SPI_MISO_SYNC_EN: defined -> miso passes through a 2-flop synchronizer clocked by sys_clk before capture; capture point unchanged (sclk 1->0 cycle), so effective slave output setup requirement is 2 sys_clk longer; CLK_DIV must be >=3. Not defined -> miso sampled directly; no extra latency; CLK_DIV>=1.

Test Plan:
- Reset then start with cmd=0x80, data=0x00, CLK_DIV=4, GAP=2 -> mosi bit sequence 1,0,0,0,0,0,0,0 then eight 0s on rising sclk; ss high 64 cycles, low 2, high 64; done at N+133; busy clears with done.
- cmd=0x9B, data=0xAA with loopback model (slave echoes previous byte, first byte returns 0x00) -> rx_cmd=0x00, rx_data=0x9B, done pulse width 1.
- miso tied high -> rx_cmd=0xFF, rx_data=0xFF; miso toggled per falling sclk starting 1 -> rx_cmd=0xAA.
- start pulsed repeatedly while busy -> single transaction, exactly 32 rising sclk edges, one done.
- rst asserted during 5th bit of data byte -> next cycle ss=0, sclk=0, mosi=0, busy=0, rx_*=0, no done; fresh start afterward completes normally.
- start held high through done cycle -> second transaction begins at N+134 with ss=1; total 64 rising sclk edges, two done pulses 133 cycles apart.
